fx3_socket_arbiter: RTL and testbench
=====================================

// Module: fx3_socket_arbiter
// PURPOSE
//  Time-shares the single FX3 GPIF socket bus between the inbound (host->FPGA) and outbound
//  (FPGA->host) DMA paths. Picks direction and ping-pong channel (CH0/CH1), drives socket address,
//  issues one grant at a time and inserts a bus turnaround gap between transfers.
//  Sits between the FX3 flag inputs and the in/out path engines, next to the bus controller.
// PARAMETERS
//  TURNAROUND_CYCLES  2      idle cycles after each release before next grant (legal range 1..15)
//  TIMEOUT_CYCLES     65535  max cycles a grant may stay high without done (TIMEOUT feature only)
// PORTS
//  clk             in   1  clock
//  rst             in   1  reset: synchronous, active-high
//  i_master_rdy    in   1  master can accept/produce data; gates new grants only
//  i_in_ch0_rdy    in   1  FX3 inbound socket CH0 has data
//  i_in_ch1_rdy    in   1  FX3 inbound socket CH1 has data
//  i_out_ch0_rdy   in   1  FX3 outbound socket CH0 has free buffer
//  i_out_ch1_rdy   in   1  FX3 outbound socket CH1 has free buffer
//  i_out_req       in   1  out path has data pending
//  o_in_grant      out  1  inbound path owns bus
//  i_in_done       in   1  1-cycle pulse: inbound transfer complete
//  o_out_grant     out  1  outbound path owns bus
//  i_out_done      in   1  1-cycle pulse: outbound transfer complete
//  o_socket_addr   out  2  {dir(1=out), channel}; stable for whole grant
//  o_busy          out  1  state != IDLE
//  o_timeout       out  1  1-cycle pulse: grant force-released (0 when feature off)
// BEHAVIOUR
//  Reset: state IDLE; o_in_grant/o_out_grant/o_timeout 0; o_socket_addr 0; last_dir 1 (in wins
//   first tie); in/out last-channel bits 1 (CH0 picked first); counters 0.
//  States: IDLE, GRANT_IN, GRANT_OUT, TURNAROUND. All outputs registered.
//  in_req = i_master_rdy & (in_ch0|in_ch1); out_req = i_master_rdy & i_out_req & (out_ch0|out_ch1).
//  IDLE: only in_req -> GRANT_IN; only out_req -> GRANT_OUT; both -> direction != last_dir.
//   Grant and o_socket_addr update on same edge; request sampled cycle N -> grant high cycle N+1.
//  Channel pick: other channel than last used for that direction if ready, else the ready one.
//   Picked channel becomes last-used; last_dir updated at grant.
//  GRANT_x: hold grant/addr regardless of rdy flags or i_master_rdy drop. Matching done ->
//   grant 0 next cycle, TURNAROUND. Done from non-granted path, or in IDLE/TURNAROUND, ignored.
//  Done in same cycle as grant edge (first grant cycle) is honoured.
//  TURNAROUND: count TURNAROUND_CYCLES cycles with no grant, then IDLE (re-arbitrate next cycle).
//   Minimum release->next-grant gap = TURNAROUND_CYCLES+1 cycles.
//  Never both grants high. o_socket_addr holds last value outside grants.
//  rst mid-grant: grant drops next edge; no done expected afterward.
// CONFIGURATION
//  FX3_ARB_TIMEOUT_EN defined: $clog2(TIMEOUT_CYCLES+1)-bit counter clears on grant, increments
//   each grant cycle; reaching TIMEOUT_CYCLES without done -> grant 0, o_timeout pulse 1 cycle,
//   TURNAROUND. Done on the same cycle wins (no timeout).
//  Undefined: no counter; o_timeout tied 0; grants wait indefinitely for done.
// STRUCTURE
//  Shared package/include: state encodings, socket address constants (IN_CH0=0, IN_CH1=1,
//   OUT_CH0=2, OUT_CH1=3), SOCKET_DIR_BIT=1.
//  Sub-module fx3_pingpong_select (2 rdy bits + last bit -> valid + chosen channel), one instance
//   per direction. Rest flat.
// TESTING
//  Only in_ch0_rdy, master_rdy=1 -> o_in_grant next cycle, addr=0; in_done -> grant low, gap 3 cycles.
//  in_ch0 & in_ch1 held rdy, 3 transfers -> addr sequence 0,1,0.
//  in and out both pending continuously -> grants alternate IN,OUT,IN; never overlap.
//  i_master_rdy=0 with all rdy -> no grant; drop master_rdy mid-grant -> grant held until done.
//  FX3_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no done -> o_timeout pulse at cycle 16, grant released.
//  rst during GRANT_OUT -> outputs at reset values next cycle; stray i_out_done then ignored.

Source files
------------

// File: rtl/fx3_socket_arbiter_pkg.sv
// Shared constants for the FX3 socket arbiter: FSM state encodings and socket addresses.
package fx3_socket_arbiter_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT_IN  = 2'd1;
  localparam logic [1:0] ST_GRANT_OUT = 2'd2;
  localparam logic [1:0] ST_TURN      = 2'd3;

  localparam logic [1:0] IN_CH0  = 2'd0;
  localparam logic [1:0] IN_CH1  = 2'd1;
  localparam logic [1:0] OUT_CH0 = 2'd2;
  localparam logic [1:0] OUT_CH1 = 2'd3;

  localparam int SOCKET_DIR_BIT = 1;

  function automatic logic [1:0] sock_addr(input logic dir, input logic ch);
    logic [1:0] a;
    a                 = '0;
    a[SOCKET_DIR_BIT] = dir;
    a[0]              = ch;
    return a;
  endfunction

endpackage

// File: rtl/fx3_socket_arbiter_if.sv
// Flag, request, grant and done signals between the FX3 paths and the socket arbiter.
interface fx3_socket_arbiter_if;
  logic       i_master_rdy;
  logic       i_in_ch0_rdy;
  logic       i_in_ch1_rdy;
  logic       i_out_ch0_rdy;
  logic       i_out_ch1_rdy;
  logic       i_out_req;
  logic       i_in_done;
  logic       i_out_done;
  logic       o_in_grant;
  logic       o_out_grant;
  logic [1:0] o_socket_addr;
  logic       o_busy;
  logic       o_timeout;

  modport slave (
    input  i_master_rdy, i_in_ch0_rdy, i_in_ch1_rdy, i_out_ch0_rdy, i_out_ch1_rdy,
    input  i_out_req, i_in_done, i_out_done,
    output o_in_grant, o_out_grant, o_socket_addr, o_busy, o_timeout
  );

  modport master (
    output i_master_rdy, i_in_ch0_rdy, i_in_ch1_rdy, i_out_ch0_rdy, i_out_ch1_rdy,
    output i_out_req, i_in_done, i_out_done,
    input  o_in_grant, o_out_grant, o_socket_addr, o_busy, o_timeout
  );
endinterface

// File: rtl/fx3_socket_arbiter_pingpong_select.sv
// Ping-pong channel chooser: prefers the channel not used last, falls back to the ready one.
module fx3_pingpong_select (
  input  logic rdy0_i,
  input  logic rdy1_i,
  input  logic last_i,
  output logic valid_o,
  output logic ch_o
);

  assign valid_o = rdy0_i | rdy1_i;
  // last_i=1 means CH1 was used last, so CH0 is preferred
  assign ch_o    = last_i ? !rdy0_i : rdy1_i;

endmodule

// File: rtl/fx3_socket_arbiter.sv
// FX3 GPIF socket bus arbiter between inbound and outbound DMA paths with turnaround gap.
// Optional grant watchdog enabled by defining FX3_ARB_TIMEOUT_EN.
module fx3_socket_arbiter
  import fx3_socket_arbiter_pkg::*;
#(
  parameter int TURNAROUND_CYCLES = 2,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input logic                 clk,
  input logic                 rst,
  fx3_socket_arbiter_if.slave bus
);

  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic       in_grant_q, in_grant_d;
  logic       out_grant_q, out_grant_d;
  logic [1:0] addr_q, addr_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic       last_dir_q, last_dir_d;
  logic       last_in_q, last_in_d;
  logic       last_out_q, last_out_d;
  logic [3:0] turn_cnt_q, turn_cnt_d;

  logic in_valid, in_ch, out_valid, out_ch;
  logic in_req, out_req;

  fx3_pingpong_select u_sel_in (
    .rdy0_i  (bus.i_in_ch0_rdy),
    .rdy1_i  (bus.i_in_ch1_rdy),
    .last_i  (last_in_q),
    .valid_o (in_valid),
    .ch_o    (in_ch)
  );

  fx3_pingpong_select u_sel_out (
    .rdy0_i  (bus.i_out_ch0_rdy),
    .rdy1_i  (bus.i_out_ch1_rdy),
    .last_i  (last_out_q),
    .valid_o (out_valid),
    .ch_o    (out_ch)
  );

  assign in_req  = bus.i_master_rdy & in_valid;
  assign out_req = bus.i_master_rdy & bus.i_out_req & out_valid;

`ifdef FX3_ARB_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_hit;
  assign to_hit = (to_cnt_q == TO_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d     = state_q;
    in_grant_d  = in_grant_q;
    out_grant_d = out_grant_q;
    addr_d      = addr_q;
    timeout_d   = 1'b0;
    last_dir_d  = last_dir_q;
    last_in_d   = last_in_q;
    last_out_d  = last_out_q;
    turn_cnt_d  = turn_cnt_q;
`ifdef FX3_ARB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // on a tie the direction not served last goes first (last_dir=1 means out)
        if (in_req && (!out_req || last_dir_q)) begin
          state_d    = ST_GRANT_IN;
          in_grant_d = 1'b1;
          addr_d     = sock_addr(1'b0, in_ch);
          last_dir_d = 1'b0;
          last_in_d  = in_ch;
`ifdef FX3_ARB_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end else if (out_req) begin
          state_d     = ST_GRANT_OUT;
          out_grant_d = 1'b1;
          addr_d      = sock_addr(1'b1, out_ch);
          last_dir_d  = 1'b1;
          last_out_d  = out_ch;
`ifdef FX3_ARB_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
      end
      ST_GRANT_IN, ST_GRANT_OUT: begin
        if ((state_q == ST_GRANT_IN) ? bus.i_in_done : bus.i_out_done) begin
          state_d     = ST_TURN;
          in_grant_d  = 1'b0;
          out_grant_d = 1'b0;
          turn_cnt_d  = '0;
`ifdef FX3_ARB_TIMEOUT_EN
        end else if (to_hit) begin
          state_d     = ST_TURN;
          in_grant_d  = 1'b0;
          out_grant_d = 1'b0;
          turn_cnt_d  = '0;
          timeout_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d    = ST_IDLE;
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 4'd1;
        end
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_grant_q  <= 1'b0;
      out_grant_q <= 1'b0;
      addr_q      <= IN_CH0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      last_dir_q  <= 1'b1;
      last_in_q   <= 1'b1;
      last_out_q  <= 1'b1;
      turn_cnt_q  <= '0;
`ifdef FX3_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_grant_q  <= in_grant_d;
      out_grant_q <= out_grant_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      last_dir_q  <= last_dir_d;
      last_in_q   <= last_in_d;
      last_out_q  <= last_out_d;
      turn_cnt_q  <= turn_cnt_d;
`ifdef FX3_ARB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign bus.o_in_grant    = in_grant_q;
  assign bus.o_out_grant   = out_grant_q;
  assign bus.o_socket_addr = addr_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_timeout     = timeout_q;

endmodule

// File: tb/tb_fx3_socket_arbiter.sv
// Directed bench for fx3_socket_arbiter (TURNAROUND_CYCLES=2, TIMEOUT_CYCLES=16).
module tb_fx3_socket_arbiter;
  import fx3_socket_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  fx3_socket_arbiter_if bus ();

  fx3_socket_arbiter #(
    .TURNAROUND_CYCLES (2),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.i_master_rdy  = 1'b0;
    bus.i_in_ch0_rdy  = 1'b0;
    bus.i_in_ch1_rdy  = 1'b0;
    bus.i_out_ch0_rdy = 1'b0;
    bus.i_out_ch1_rdy = 1'b0;
    bus.i_out_req     = 1'b0;
    bus.i_in_done     = 1'b0;
    bus.i_out_done    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_in_grant !== 1'b0 || bus.o_out_grant !== 1'b0) begin
      failures++;
      $display("FAIL reset_grants got in=%b out=%b want 0 0", bus.o_in_grant, bus.o_out_grant);
    end
    checks++;
    if (bus.o_socket_addr !== 2'd0 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_addr_busy got addr=%0d busy=%b want 0 0", bus.o_socket_addr, bus.o_busy);
    end
    checks++;
    if (bus.o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_timeout got %b want 0", bus.o_timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_in();
    int gap;
    do_reset();
    bus.i_master_rdy = 1'b1;
    bus.i_in_ch0_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_in_grant !== 1'b1 || bus.o_out_grant !== 1'b0 || bus.o_socket_addr !== IN_CH0 || bus.o_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant got in=%b out=%b addr=%0d busy=%b want 1 0 0 1",
               bus.o_in_grant, bus.o_out_grant, bus.o_socket_addr, bus.o_busy);
    end
    bus.i_in_ch0_rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_in_grant !== 1'b1) begin
      failures++;
      $display("FAIL single_hold got %b want 1", bus.o_in_grant);
    end
    bus.i_in_done = 1'b1;
    @(negedge clk);
    bus.i_in_done    = 1'b0;
    bus.i_in_ch0_rdy = 1'b1;
    gap = 0;
    for (int k = 0; k < 10 && bus.o_in_grant !== 1'b1; k++) begin
      gap++;
      @(negedge clk);
    end
    checks++;
    if (gap !== 3) begin
      failures++;
      $display("FAIL single_gap got %0d want 3", gap);
    end
    checks++;
    if (bus.o_in_grant !== 1'b1 || bus.o_socket_addr !== IN_CH0) begin
      failures++;
      $display("FAIL single_regrant got grant=%b addr=%0d want 1 0", bus.o_in_grant, bus.o_socket_addr);
    end
    bus.i_in_ch0_rdy = 1'b0;
    bus.i_in_done    = 1'b1;
    @(negedge clk);
    bus.i_in_done = 1'b0;
  endtask

  task automatic test_pingpong();
    logic [1:0] got [3];
    logic [1:0] exp_addr [3];
    exp_addr[0] = IN_CH0;
    exp_addr[1] = IN_CH1;
    exp_addr[2] = IN_CH0;
    do_reset();
    bus.i_master_rdy = 1'b1;
    bus.i_in_ch0_rdy = 1'b1;
    bus.i_in_ch1_rdy = 1'b1;
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 10 && bus.o_in_grant !== 1'b1; k++) @(negedge clk);
      got[t] = (bus.o_in_grant === 1'b1) ? bus.o_socket_addr : 2'bxx;
      bus.i_in_done = 1'b1;
      @(negedge clk);
      bus.i_in_done = 1'b0;
    end
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (got[t] !== exp_addr[t]) begin
        failures++;
        $display("FAIL pingpong_addr%0d got %0d want %0d", t, got[t], exp_addr[t]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_alternate();
    logic [1:0] got [3];
    logic       got_out [3];
    logic [1:0] exp_addr [3];
    logic       exp_out [3];
    int         overlap;
    exp_addr[0] = IN_CH0;  exp_out[0] = 1'b0;
    exp_addr[1] = OUT_CH0; exp_out[1] = 1'b1;
    exp_addr[2] = IN_CH0;  exp_out[2] = 1'b0;
    overlap = 0;
    do_reset();
    bus.i_master_rdy  = 1'b1;
    bus.i_in_ch0_rdy  = 1'b1;
    bus.i_out_ch0_rdy = 1'b1;
    bus.i_out_req     = 1'b1;
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 10 && bus.o_in_grant !== 1'b1 && bus.o_out_grant !== 1'b1; k++) begin
        if (bus.o_in_grant === 1'b1 && bus.o_out_grant === 1'b1) overlap++;
        @(negedge clk);
      end
      if (bus.o_in_grant === 1'b1 && bus.o_out_grant === 1'b1) overlap++;
      got[t]     = bus.o_socket_addr;
      got_out[t] = bus.o_out_grant;
      if (bus.o_out_grant === 1'b1) bus.i_out_done = 1'b1;
      else                          bus.i_in_done  = 1'b1;
      @(negedge clk);
      bus.i_in_done  = 1'b0;
      bus.i_out_done = 1'b0;
    end
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (got_out[t] !== exp_out[t] || got[t] !== exp_addr[t]) begin
        failures++;
        $display("FAIL alternate%0d got out=%b addr=%0d want out=%b addr=%0d",
                 t, got_out[t], got[t], exp_out[t], exp_addr[t]);
      end
    end
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL alternate_overlap got %0d cycles want 0", overlap);
    end
    clear_inputs();
  endtask

  task automatic test_master_rdy();
    int bad;
    int held;
    do_reset();
    bus.i_in_ch0_rdy  = 1'b1;
    bus.i_in_ch1_rdy  = 1'b1;
    bus.i_out_ch0_rdy = 1'b1;
    bus.i_out_ch1_rdy = 1'b1;
    bus.i_out_req     = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.o_in_grant !== 1'b0 || bus.o_out_grant !== 1'b0 || bus.o_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL mrdy_gate got %0d granted cycles want 0", bad);
    end
    bus.i_master_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_in_grant !== 1'b1 || bus.o_out_grant !== 1'b0 || bus.o_socket_addr !== IN_CH0) begin
      failures++;
      $display("FAIL mrdy_grant got in=%b out=%b addr=%0d want 1 0 0",
               bus.o_in_grant, bus.o_out_grant, bus.o_socket_addr);
    end
    bus.i_master_rdy = 1'b0;
    bus.i_out_done   = 1'b1;
    @(negedge clk);
    bus.i_out_done = 1'b0;
    held = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.o_in_grant === 1'b1 && bus.o_out_grant === 1'b0 && bus.o_socket_addr === IN_CH0) held++;
      if (k < 3) @(negedge clk);
    end
    checks++;
    if (held !== 4) begin
      failures++;
      $display("FAIL mrdy_hold got %0d held cycles want 4", held);
    end
    bus.i_in_done = 1'b1;
    @(negedge clk);
    bus.i_in_done = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.o_in_grant !== 1'b0 || bus.o_out_grant !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL mrdy_release got %0d granted cycles want 0", bad);
    end
    clear_inputs();
  endtask

  task automatic test_rst_mid_grant();
    int bad;
    do_reset();
    bus.i_master_rdy  = 1'b1;
    bus.i_out_ch1_rdy = 1'b1;
    bus.i_out_req     = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_out_grant !== 1'b1 || bus.o_in_grant !== 1'b0 || bus.o_socket_addr !== OUT_CH1) begin
      failures++;
      $display("FAIL rst_out_grant got out=%b in=%b addr=%0d want 1 0 3",
               bus.o_out_grant, bus.o_in_grant, bus.o_socket_addr);
    end
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_out_grant !== 1'b0 || bus.o_socket_addr !== 2'd0 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got out=%b addr=%0d busy=%b want 0 0 0",
               bus.o_out_grant, bus.o_socket_addr, bus.o_busy);
    end
    rst = 1'b0;
    bus.i_out_done = 1'b1;
    @(negedge clk);
    bus.i_out_done = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.o_out_grant !== 1'b0 || bus.o_in_grant !== 1'b0 || bus.o_busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rst_stray_done got %0d active cycles want 0", bad);
    end
  endtask

`ifdef FX3_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int held;
    do_reset();
    bus.i_master_rdy = 1'b1;
    bus.i_in_ch0_rdy = 1'b1;
    @(negedge clk);
    bus.i_in_ch0_rdy = 1'b0;
    held = 0;
    for (int k = 0; k < 16; k++) begin
      if (bus.o_in_grant === 1'b1 && bus.o_timeout === 1'b0) held++;
      @(negedge clk);
    end
    checks++;
    if (held !== 16) begin
      failures++;
      $display("FAIL timeout_hold got %0d cycles want 16", held);
    end
    checks++;
    if (bus.o_in_grant !== 1'b0 || bus.o_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_fire got grant=%b timeout=%b want 0 1", bus.o_in_grant, bus.o_timeout);
    end
    @(negedge clk);
    checks++;
    if (bus.o_timeout !== 1'b0 || bus.o_busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pulse got timeout=%b busy=%b want 0 1", bus.o_timeout, bus.o_busy);
    end
    clear_inputs();
    repeat (4) @(negedge clk);
  endtask
`else
  task automatic test_no_timeout();
    int held;
    do_reset();
    bus.i_master_rdy = 1'b1;
    bus.i_in_ch0_rdy = 1'b1;
    @(negedge clk);
    bus.i_in_ch0_rdy = 1'b0;
    held = 0;
    for (int k = 0; k < 24; k++) begin
      if (bus.o_in_grant === 1'b1 && bus.o_timeout === 1'b0) held++;
      @(negedge clk);
    end
    checks++;
    if (held !== 24) begin
      failures++;
      $display("FAIL no_timeout_hold got %0d cycles want 24", held);
    end
    bus.i_in_done = 1'b1;
    @(negedge clk);
    bus.i_in_done = 1'b0;
    checks++;
    if (bus.o_in_grant !== 1'b0 || bus.o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout_done got grant=%b timeout=%b want 0 0", bus.o_in_grant, bus.o_timeout);
    end
    clear_inputs();
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_in();
    test_pingpong();
    test_alternate();
    test_master_rdy();
    test_rst_mid_grant();
`ifdef FX3_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
